// File: rtl/dsram_ctrl_pkg.sv
// Shared memop codes, size codes and FSM encodings for the data SRAM controller.
// Also holds the helpers that classify memops, including the alignment check.
package dsram_ctrl_pkg;

    localparam int MMOP_W = 4;

    typedef enum logic [MMOP_W-1:0] {
        MOP_NOP = 4'd0,
        MOP_LB  = 4'd1,
        MOP_LBU = 4'd2,
        MOP_LH  = 4'd3,
        MOP_LHU = 4'd4,
        MOP_LW  = 4'd5,
        MOP_SB  = 4'd6,
        MOP_SH  = 4'd7,
        MOP_SW  = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    function automatic logic op_is_store(input memop_e op);
        return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
    endfunction

    function automatic size_e op_size(input memop_e op);
        case (op)
            MOP_LB, MOP_LBU, MOP_SB: return SIZE_BYTE;
            MOP_LH, MOP_LHU, MOP_SH: return SIZE_HALF;
            default:                 return SIZE_WORD;
        endcase
    endfunction

    // The slave picks lanes from addr[1:0] and size, so stores go out replicated.
    function automatic logic [31:0] lane_wdata(input memop_e op, input logic [31:0] wd);
        case (op)
            MOP_SB:  return {4{wd[7:0]}};
            MOP_SH:  return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic op_misaligned(input memop_e op, input logic [1:0] low);
        case (op_size(op))
            SIZE_HALF: return low[0];
            SIZE_WORD: return low != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dsram_ctrl_load_align.sv
// Combinational load extraction: picks the byte/half lane from the raw read word
// and sign- or zero-extends it according to the memop.
module dsram_ctrl_load_align
    import dsram_ctrl_pkg::*;
(
    input  logic [31:0]       rdata,
    input  logic [1:0]        offset,
    input  logic [MMOP_W-1:0] memop,
    output logic [31:0]       result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        case (memop_e'(memop))
            MOP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MOP_LBU: result = {24'd0, byte_sel};
            MOP_LH:  result = {{16{half_sel[15]}}, half_sel};
            MOP_LHU: result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/dsram_ctrl.sv
// Memory-stage data SRAM controller: one load/store becomes one req/addr_ok/data_ok
// transaction. Define MISALIGN_CHECK_EN to add the adel_o/ades_o alignment checks.
module dsram_ctrl
    import dsram_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid_i,
    input  logic [MMOP_W-1:0] mem_memop_i,
    input  logic [AW-1:0]     mem_addr_i,
    input  logic [DW-1:0]     mem_wdata_i,
    input  logic              flush_i,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [AW-1:0]     data_addr_o,
    output logic [DW-1:0]     data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [DW-1:0]     data_rdata_i,
    output logic              ld_valid_o,
    output logic [DW-1:0]     ld_data_o,
    output logic              mem_stall_o
`ifdef MISALIGN_CHECK_EN
    ,
    output logic              adel_o,
    output logic              ades_o
`endif
);

    state_e        state;
    logic          cancel;
    memop_e        op_q;
    memop_e        op_in;
    logic          would_accept;
    logic          accept;
    logic [DW-1:0] aligned;

    assign op_in        = memop_e'(mem_memop_i);
    assign would_accept = mem_valid_i & (op_in != MOP_NOP) & ~flush_i & (state == ST_IDLE);

`ifdef MISALIGN_CHECK_EN
    logic misal;
    assign misal  = op_misaligned(op_in, mem_addr_i[1:0]);
    assign adel_o = would_accept & misal & ~op_is_store(op_in);
    assign ades_o = would_accept & misal & op_is_store(op_in);
    assign accept = would_accept & ~misal;
`else
    assign accept = would_accept;
`endif

    assign mem_stall_o = accept | (state == ST_REQ) | ((state == ST_WAIT) & ~data_data_ok_i);

    dsram_ctrl_load_align u_load_align (
        .rdata  (data_rdata_i),
        .offset (data_addr_o[1:0]),
        .memop  (op_q),
        .result (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cancel       <= 1'b0;
            op_q         <= MOP_NOP;
            data_req_o   <= 1'b0;
            data_wr_o    <= 1'b0;
            data_size_o  <= 2'd0;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
            ld_valid_o   <= 1'b0;
            ld_data_o    <= '0;
        end else begin
            ld_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state        <= ST_REQ;
                        cancel       <= 1'b0;
                        op_q         <= op_in;
                        data_req_o   <= 1'b1;
                        data_wr_o    <= op_is_store(op_in);
                        data_size_o  <= op_size(op_in);
                        data_addr_o  <= mem_addr_i;
                        data_wdata_o <= lane_wdata(op_in, mem_wdata_i);
                    end
                end
                ST_REQ: begin
                    if (flush_i) cancel <= 1'b1;
                    if (data_addr_ok_i) begin
                        state      <= ST_WAIT;
                        data_req_o <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (flush_i) cancel <= 1'b1;
                    if (data_data_ok_i) begin
                        state  <= ST_IDLE;
                        cancel <= 1'b0;
                        // A flush arriving with data_ok also discards the result.
                        if (!data_wr_o && !cancel && !flush_i) begin
                            ld_valid_o <= 1'b1;
                            ld_data_o  <= aligned;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dsram_ctrl.md
Name: dsram_ctrl

Overview:
- Controls the data SRAM for the memory stage. It turns one memory-stage load/store into one SRAM-like bus transaction (req/addr_ok/data_ok), aligns and extends load data, and drives the memory-stage stall.
- Sits between the ex/mem pipeline register and the data SRAM port.
- Supplies the memdata and stall inputs that the memory-stage writeback register consumes.

Parameters:
- AW, 32, address width
- DW, 32, data width (fixed at 32; byte lanes assume 4 bytes)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid_i  in  1  memory-stage instruction valid
- mem_memop_i  in  4  memop code (shared defines)
- mem_addr_i  in  AW  effective address
- mem_wdata_i  in  DW  store data (rt)
- flush_i  in  1  pipeline flush (exception/eret)
- data_req_o  out  1  bus request
- data_wr_o  out  1  1=store
- data_size_o  out  2  0=byte, 1=half, 2=word
- data_addr_o  out  AW  request address
- data_wdata_o  out  DW  lane-replicated store data
- data_addr_ok_i  in  1  request accepted
- data_data_ok_i  in  1  data returned / write done
- data_rdata_i  in  DW  raw read data
- ld_valid_o  out  1  one-cycle load-result strobe
- ld_data_o  out  DW  aligned, extended load result
- mem_stall_o  out  1  hold memory stage and earlier

Behaviour:
- Reset is asynchronous, active-low:
  - State = IDLE, cancel = 0.
  - All registered outputs are 0, including data_req_o, ld_valid_o and ld_data_o.
- States and transitions:
  - IDLE -> REQ: on accept = mem_valid_i & memop!=NOP & ~flush_i. Latch op, addr, size and lane-replicated wdata.
  - REQ: data_req_o=1 with all data_* outputs stable. On data_addr_ok_i -> WAIT. The request is never withdrawn before addr_ok.
  - WAIT: on data_data_ok_i -> IDLE.
    - For a load with cancel=0: ld_data_o is registered and ld_valid_o=1 for exactly the next cycle.
    - For a store: no strobe.
- Latency: load result appears 1 cycle after data_ok; minimum total is accept + 3 cycles.
- Only one outstanding transaction. No new accept until state returns to IDLE, so back-to-back operations are separated by at least one IDLE cycle.
- The bus guarantees data_ok at least one cycle after addr_ok. data_ok seen in REQ or IDLE is ignored.
- mem_stall_o is combinational: accept | REQ | (WAIT & ~data_data_ok_i).
- Flush:
  - In REQ or WAIT, flush sets cancel. The transaction completes on the bus, its data is discarded, and no ld_valid_o is produced.
  - cancel clears on return to IDLE.
  - Stall stays asserted until retirement.
  - flush_i together with mem_valid_i in IDLE means no accept.
- Store lanes: SB -> {4{b}}, SH -> {2{h}}, SW -> word. data_addr_o is the full address; the slave uses addr[1:0] together with size.
- Load extraction:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW takes the word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Reset during REQ or WAIT returns to IDLE immediately; the bus slave is reset by the same rst_n.

Optional Feature:
- Macro MISALIGN_CHECK_EN.
- Defined:
  - Adds outputs adel_o and ades_o (1 bit each), combinational, high in the cycle of a would-be accept.
  - Half with addr[0]=1, or word with addr[1:0]!=0, raises adel_o for loads or ades_o for stores. No request is issued, the state stays IDLE, and stall is not asserted.
- Undefined: ports are absent, no check is made, and misaligned low bits pass straight to the bus.

Decomposition:
- Shared defines file: memop codes (NOP, LB, LBU, LH, LHU, LW, SB, SH, SW), MMOP width, size codes, FSM state encodings (IDLE=0, REQ=1, WAIT=2).
- Sub-module load_align: combinational extract/extend of (rdata, addr[1:0], memop) -> 32-bit result.
- State, cancel and latched fields use the existing DFFRE flop cell with rst_n.

Test Plan:
- LW at 0x1000, addr_ok after 2 cycles, data_ok 3 cycles later with 0xDEADBEEF -> ld_valid_o one cycle, ld_data_o=0xDEADBEEF; stall high from accept until the data_ok cycle.
- LB at 0x1003 with rdata 0x80112233 -> 0xFFFFFF80; LBU -> 0x00000080; LH at 0x1002 -> 0xFFFF8011; LHU at 0x1000 -> 0x00002233.
- SB at 0x2001 with wdata 0x000000AB -> wr=1, size=0, wdata=0xABABABAB; no ld_valid_o.
- flush_i asserted in WAIT for LW -> data_ok is consumed, no ld_valid_o, returns to IDLE; the next LW is accepted afterwards.
- Reset asserted in REQ with addr_ok never given -> data_req_o=0 and stall=0 immediately; the FSM restarts cleanly after reset.
- With MISALIGN_CHECK_EN: LW at 0x1002 -> adel_o=1, data_req_o stays 0; SH at 0x1001 -> ades_o=1.
